rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (regWrite/writeReg/writeData, written on negedge clk) between two writeback requesters: ALU result path and memory-load path.
- Each requester has a small FIFO with a valid/ready handshake.
- A fixed-priority arbiter with starvation guard drives the write port from registered outputs.
- Exports a per-register pending mask and a read-hazard flag so decode can stall reads of registers with writes still queued.

Parameters:
- ADDR_W, 5, register index width
- DATA_W, 32, write data width
- NREGS, 32, number of architectural registers (2**ADDR_W)
- FIFO_DEPTH, 2, entries per requester FIFO
- STARVE_LIMIT, 3, consecutive lost grants after which the ALU requester wins

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write request valid
- alu_ready  out  1  ALU FIFO can accept
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load write request valid
- mem_ready  out  1  mem FIFO can accept
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- rf_regWrite  out  1  to register file regWrite
- rf_writeReg  out  ADDR_W  to register file writeReg
- rf_writeData  out  DATA_W  to register file writeData
- chk_reg1, chk_reg2  in  ADDR_W  decode read indices
- chk_hazard  out  1  a queued write targets chk_reg1 or chk_reg2
- pending_mask  out  NREGS  bit r = some queued or in-flight write targets r

Behaviour:
- Reset (async, immediate):
  - both FIFOs emptied; starvation counter = 0
  - rf_regWrite = 0, rf_writeReg = 0, rf_writeData = 0
  - alu_ready = mem_ready = 0 while reset is high
  - pending_mask = 0, chk_hazard = 0
  - Queued requests are discarded when reset asserts mid-operation.
- Accept: on posedge, when x_valid && x_ready, push {addr,data} into FIFO x.
  - x_ready = !full(x); it does not depend on a same-cycle pop (no pass-through).
  - Pushing while not ready is ignored; the source holds its request.
- Register 0: requests with addr 0 are accepted and popped normally, but rf_regWrite stays 0 for them and they never set pending_mask.
- Arbitration: evaluated each posedge from FIFO heads.
  - Both empty: rf_regWrite <= 0; rf_writeReg/rf_writeData hold their previous values.
  - One non-empty: grant it.
  - Both non-empty: grant mem, unless starve_cnt == STARVE_LIMIT, in which case grant alu.
  - starve_cnt increments when alu is non-empty and loses. It clears when alu is granted or alu is empty. It saturates at STARVE_LIMIT.
  - Grant pops the head and registers rf_regWrite=1 (0 if addr 0), rf_writeReg, rf_writeData at the same posedge.
  - The register file captures at the following negedge.
- Latency: a request accepted at posedge N is granted at the earliest at posedge N+1 and written at the negedge inside cycle N+1.
  - Peak throughput is one write per cycle.
- Pending mask (combinational):
  - OR of one-hot(addr) over all valid FIFO entries, plus the currently registered rf_writeReg while rf_regWrite=1 (write not yet landed).
  - Bit 0 is forced to 0.
- chk_hazard = pending_mask[chk_reg1] | pending_mask[chk_reg2].
- Ordering: entries from one requester are written in FIFO order. Cross-requester order to the same register is arbitration order. Upstream must not issue a second write to a pending register; it uses chk_hazard/pending_mask to enforce this.
- Simultaneous push and pop on the same FIFO in one cycle: both take effect, and occupancy is unchanged.

Decomposition:
- Package rf_pkg holds:
  - constants ADDR_W, DATA_W, NREGS, REG_ZERO = 0
  - typedef wr_req_t {addr[ADDR_W], data[DATA_W]}
  - enum grant_t {GNT_NONE, GNT_ALU, GNT_MEM}
- Sub-module rf_wr_fifo: FIFO_DEPTH-entry FIFO with push/pop/full/empty and a per-entry valid+addr view for pending_mask. Instantiated twice.

Test Plan:
- Reset mid-stream: 2 entries queued per FIFO, pulse reset -> rf_regWrite=0 immediately, pending_mask=0, after release alu_ready=mem_ready=1, no writes issued.
- Single ALU write: addr 5, data 0xDEADBEEF at posedge 0 -> rf_regWrite=1, rf_writeReg=5, rf_writeData=0xDEADBEEF after posedge 1; pending_mask[5]=1 from posedge 0 until rf_regWrite drops; chk_reg1=5 gives chk_hazard=1.
- Contention: both valid every cycle, alu addrs 1..8, mem addrs 9..16 -> grant order mem,mem,mem,alu,mem,mem,mem,alu; no request lost; alu_ready drops when 2 entries are queued.
- Full FIFO: hold mem_valid with the FIFO full and no grant possible -> mem_ready=0 and the push is ignored; after one pop mem_ready=1 the same cycle.
- Register 0: alu addr 0, data 0x1234 -> accepted and popped, rf_regWrite stays 0, pending_mask[0]=0, chk_hazard=0 for chk_reg1=0.
- Back-to-back single requester: mem writes to r3,r4,r5 on consecutive cycles -> three consecutive cycles of rf_regWrite=1 with writeReg 3,4,5 in order.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and constants for the register-file write-port
//               arbiter (request record, grant encoding, widths).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Bundle of the two writeback request channels, the register
//               file write port and the decode hazard query.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_regWrite;
  logic [ADDR_W-1:0] rf_writeReg;
  logic [DATA_W-1:0] rf_writeData;
  logic [ADDR_W-1:0] chk_reg1;
  logic [ADDR_W-1:0] chk_reg2;
  logic              chk_hazard;
  logic [NREGS-1:0]  pending_mask;

  // Requester / decode side
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output chk_reg1, chk_reg2,
    input  alu_ready, mem_ready,
    input  rf_regWrite, rf_writeReg, rf_writeData,
    input  chk_hazard, pending_mask
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  chk_reg1, chk_reg2,
    output alu_ready, mem_ready,
    output rf_regWrite, rf_writeReg, rf_writeData,
    output chk_hazard, pending_mask
  );

endinterface
`default_nettype wire

// File: rtl/rf_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_fifo
// Description : Small write-request FIFO. Per-slot valid bits give full/empty
//               directly and expose every queued destination for hazard
//               tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  wr_req_t                              push_req,
  input  logic                                 pop,
  output wr_req_t                              head,
  output logic                                 full,
  output logic                                 empty,
  output logic [FIFO_DEPTH-1:0]                ent_valid,
  output logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    ent_addr
);

  localparam int              PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);

  wr_req_t               r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Payload storage; contents are don't-care while the slot is not valid
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_req;
  end

  // Slot valid bits and pointers. Push is only qualified when not full and
  // pop only when not empty, so both never touch the same slot in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= ptr_inc(r_rd_ptr);
      end
    end
  end

  assign head      = r_mem[r_rd_ptr];
  assign full      = &r_vld;
  assign empty     = ~|r_vld;
  assign ent_valid = r_vld;

  generate
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_view
      assign ent_addr[i] = r_mem[i].addr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register file write port between the ALU and the
//               load writeback paths. Memory wins by default; the ALU wins
//               after STARVE_LIMIT consecutive losses. Publishes a mask of
//               registers with writes still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);

  localparam int             SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);

  wr_req_t                          w_alu_req, w_mem_req;
  wr_req_t                          w_alu_head, w_mem_head, w_sel;
  logic                             w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
  logic                             w_alu_push, w_mem_push, w_alu_pop, w_mem_pop;
  logic [FIFO_DEPTH-1:0]            w_alu_ev, w_mem_ev;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] w_alu_ea, w_mem_ea;
  grant_t                           w_gnt;
  logic [SC_W-1:0]                  r_starve, w_starve_nxt;
  logic                             r_we;
  logic [ADDR_W-1:0]                r_reg;
  logic [DATA_W-1:0]                r_data;
  logic [NREGS-1:0]                 w_mask;

  // Ready reflects stored occupancy only; a same-cycle pop never frees a slot early
  assign bus.alu_ready = !w_alu_full && !reset;
  assign bus.mem_ready = !w_mem_full && !reset;
  assign w_alu_push    = bus.alu_valid && bus.alu_ready;
  assign w_mem_push    = bus.mem_valid && bus.mem_ready;
  assign w_alu_req     = '{addr: bus.alu_addr, data: bus.alu_data};
  assign w_mem_req     = '{addr: bus.mem_addr, data: bus.mem_data};

  rf_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset), .push(w_alu_push), .push_req(w_alu_req),
    .pop(w_alu_pop), .head(w_alu_head), .full(w_alu_full), .empty(w_alu_empty),
    .ent_valid(w_alu_ev), .ent_addr(w_alu_ea)
  );

  rf_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk(clk), .reset(reset), .push(w_mem_push), .push_req(w_mem_req),
    .pop(w_mem_pop), .head(w_mem_head), .full(w_mem_full), .empty(w_mem_empty),
    .ent_valid(w_mem_ev), .ent_addr(w_mem_ea)
  );

  // Fixed priority (mem first) with a saturating starvation counter for the ALU
  always_comb begin
    w_gnt        = GNT_NONE;
    w_starve_nxt = r_starve;
    if (!w_alu_empty && !w_mem_empty)
      w_gnt = (r_starve == SC_LIMIT) ? GNT_ALU : GNT_MEM;
    else if (!w_alu_empty)
      w_gnt = GNT_ALU;
    else if (!w_mem_empty)
      w_gnt = GNT_MEM;

    if (w_alu_empty || w_gnt == GNT_ALU)
      w_starve_nxt = '0;
    else if (r_starve != SC_LIMIT)
      w_starve_nxt = r_starve + 1'b1;
  end

  assign w_alu_pop = (w_gnt == GNT_ALU);
  assign w_mem_pop = (w_gnt == GNT_MEM);
  assign w_sel     = w_alu_pop ? w_alu_head : w_mem_head;

  // Registered write port; address and data hold while nothing is granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
      r_we     <= 1'b0;
      r_reg    <= '0;
      r_data   <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_gnt == GNT_NONE) begin
        r_we <= 1'b0;
      end else begin
        r_we   <= (w_sel.addr != REG_ZERO);
        r_reg  <= w_sel.addr;
        r_data <= w_sel.data;
      end
    end
  end

  assign bus.rf_regWrite  = r_we;
  assign bus.rf_writeReg  = r_reg;
  assign bus.rf_writeData = r_data;

  // Destinations of every queued entry plus the write that has not yet landed
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_alu_ev[i]) w_mask[w_alu_ea[i]] = 1'b1;
      if (w_mem_ev[i]) w_mask[w_mem_ea[i]] = 1'b1;
    end
    if (r_we) w_mask[r_reg] = 1'b1;
    w_mask[REG_ZERO] = 1'b0;
  end

  assign bus.pending_mask = w_mask;
  assign bus.chk_hazard   = w_mask[bus.chk_reg1] | w_mask[bus.chk_reg2];

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench: directed vector table, contention and
//               mid-stream reset sequences, then random traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit          av; logic [4:0] aa; logic [31:0] ad;
    bit          mv; logic [4:0] ma; logic [31:0] md;
    logic [4:0]  c1; logic [4:0] c2;
    bit          e_ar; bit e_mr; bit e_haz; logic [31:0] e_mask;
    bit          e_we; logic [4:0] e_reg; logic [31:0] e_data;
  } vec_t;

  // Reference model: two bounded queues, a loss counter, and the write port
  req_t        aq[$];
  req_t        mq[$];
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_starve;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete(); mq.delete();
    m_we = 1'b0; m_reg = '0; m_data = '0; m_starve = 0;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (aq[i]) m[aq[i].addr] = 1'b1;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    if (m_we) m[m_reg] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_edge(input bit av, input req_t ar, input bit mv, input req_t mr);
    bit   acc_a, acc_m, ane, mne, take_a;
    req_t g;
    acc_a = av && (aq.size() < 2);
    acc_m = mv && (mq.size() < 2);
    ane   = aq.size() > 0;
    mne   = mq.size() > 0;
    if (!ane && !mne) begin
      m_we     = 1'b0;
      m_starve = 0;
    end else begin
      take_a = ane && (!mne || m_starve == 3);
      if (take_a) g = aq.pop_front();
      else        g = mq.pop_front();
      m_we   = (g.addr != 5'd0);
      m_reg  = g.addr;
      m_data = g.data;
      if (!ane || take_a) m_starve = 0;
      else if (m_starve < 3) m_starve = m_starve + 1;
    end
    if (acc_a) aq.push_back(ar);
    if (acc_m) mq.push_back(mr);
  endtask

  // One clock: check combinational outputs, step model, check registered outputs
  task automatic run_cycle(input bit av, input req_t ar, input bit mv, input req_t mr,
                           input logic [4:0] c1, input logic [4:0] c2,
                           output bit a_acc, output bit m_acc);
    logic [31:0] mm;
    bus.alu_valid = av; bus.alu_addr = ar.addr; bus.alu_data = ar.data;
    bus.mem_valid = mv; bus.mem_addr = mr.addr; bus.mem_data = mr.data;
    bus.chk_reg1 = c1;  bus.chk_reg2 = c2;
    #1;
    mm = model_mask();
    check("alu_ready", bus.alu_ready, aq.size() < 2);
    check("mem_ready", bus.mem_ready, mq.size() < 2);
    check("pending_mask", bus.pending_mask, mm);
    check("chk_hazard", bus.chk_hazard, mm[c1] | mm[c2]);
    a_acc = av && (aq.size() < 2);
    m_acc = mv && (mq.size() < 2);
    model_edge(av, ar, mv, mr);
    @(posedge clk); #1;
    check("rf_regWrite", bus.rf_regWrite, m_we);
    check("rf_writeReg", bus.rf_writeReg, m_reg);
    check("rf_writeData", bus.rf_writeData, m_data);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.chk_reg1 = '0; bus.chk_reg2 = '0;
  endtask

  // Enters and leaves one time unit after a rising edge
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                              input bit mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] c1, input logic [4:0] c2,
                              input bit e_ar, input bit e_mr, input bit e_haz,
                              input logic [31:0] e_mask, input bit e_we,
                              input logic [4:0] e_reg, input logic [31:0] e_data);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.c1 = c1; v.c2 = c2; v.e_ar = e_ar; v.e_mr = e_mr; v.e_haz = e_haz;
    v.e_mask = e_mask; v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data;
    return v;
  endfunction

  vec_t tbl[11];
  int   wlog[$];

  initial begin
    req_t ra, rm;
    bit   a_acc, m_acc;
    int   a_next, m_next;
    bit   seen_a_full, seen_m_full;
    int   cnt[32];
    int   exp_order[8];

    // ---------------- reset state ----------------
    idle_inputs();
    #1;
    check("reset_regWrite", bus.rf_regWrite, 1'b0);
    check("reset_writeReg", bus.rf_writeReg, 5'd0);
    check("reset_writeData", bus.rf_writeData, 32'd0);
    check("reset_alu_ready", bus.alu_ready, 1'b0);
    check("reset_mem_ready", bus.mem_ready, 1'b0);
    check("reset_mask", bus.pending_mask, 32'd0);
    check("reset_hazard", bus.chk_hazard, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // ---------------- directed vector table ----------------
    //           av aa     ad            mv ma     md        c1     c2     ar mr hz mask          we reg    data
    tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 32'h0);
    tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 1, 32'h0000_0020, 1, 5'd5, 32'hDEADBEEF);
    tbl[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 1, 32'h0000_0020, 0, 5'd5, 32'hDEADBEEF);
    tbl[3]  = mk(1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 1, 0, 32'h0000_0000, 0, 5'd5, 32'hDEADBEEF);
    tbl[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 32'h1234);
    tbl[5]  = mk(0, 5'd0, 32'h0,        1, 5'd3, 32'h33, 5'd3, 5'd4, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 32'h1234);
    tbl[6]  = mk(0, 5'd0, 32'h0,        1, 5'd4, 32'h44, 5'd3, 5'd4, 1, 1, 1, 32'h0000_0008, 1, 5'd3, 32'h33);
    tbl[7]  = mk(0, 5'd0, 32'h0,        1, 5'd5, 32'h55, 5'd3, 5'd4, 1, 1, 1, 32'h0000_0018, 1, 5'd4, 32'h44);
    tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 5'd4, 1, 1, 1, 32'h0000_0030, 1, 5'd5, 32'h55);
    tbl[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 5'd4, 1, 1, 0, 32'h0000_0020, 0, 5'd5, 32'h55);
    tbl[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 5'd4, 1, 1, 0, 32'h0000_0000, 0, 5'd5, 32'h55);

    for (int i = 0; i < 11; i++) begin
      bus.alu_valid = tbl[i].av; bus.alu_addr = tbl[i].aa; bus.alu_data = tbl[i].ad;
      bus.mem_valid = tbl[i].mv; bus.mem_addr = tbl[i].ma; bus.mem_data = tbl[i].md;
      bus.chk_reg1 = tbl[i].c1;  bus.chk_reg2 = tbl[i].c2;
      #1;
      check($sformatf("vec%0d_alu_ready", i), bus.alu_ready, tbl[i].e_ar);
      check($sformatf("vec%0d_mem_ready", i), bus.mem_ready, tbl[i].e_mr);
      check($sformatf("vec%0d_hazard", i), bus.chk_hazard, tbl[i].e_haz);
      check($sformatf("vec%0d_mask", i), bus.pending_mask, tbl[i].e_mask);
      @(posedge clk); #1;
      check($sformatf("vec%0d_regWrite", i), bus.rf_regWrite, tbl[i].e_we);
      check($sformatf("vec%0d_writeReg", i), bus.rf_writeReg, tbl[i].e_reg);
      check($sformatf("vec%0d_writeData", i), bus.rf_writeData, tbl[i].e_data);
    end

    // ---------------- contention: both requesters always valid ----------------
    do_reset();
    exp_order = '{9, 10, 11, 1, 12, 13, 14, 2};
    a_next = 1; m_next = 9;
    seen_a_full = 1'b0; seen_m_full = 1'b0;
    wlog.delete();
    for (int c = 0; c < 44; c++) begin
      ra.addr = a_next[4:0]; ra.data = 32'hA000_0000 | a_next;
      rm.addr = m_next[4:0]; rm.data = 32'hB000_0000 | m_next;
      run_cycle(a_next <= 8, ra, m_next <= 16, rm, 5'd1, 5'd9, a_acc, m_acc);
      if (a_acc) a_next++;
      if (m_acc) m_next++;
      if (bus.rf_regWrite) wlog.push_back(int'(bus.rf_writeReg));
      if (!bus.alu_ready) seen_a_full = 1'b1;
      if (!bus.mem_ready) seen_m_full = 1'b1;
    end
    check("contention_writes", wlog.size(), 16);
    for (int i = 0; i < 8; i++)
      check($sformatf("grant_order%0d", i), (i < wlog.size()) ? wlog[i] : -1, exp_order[i]);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (wlog[i]) cnt[wlog[i]]++;
    for (int r = 1; r <= 16; r++)
      check($sformatf("written_once_r%0d", r), cnt[r], 1);
    check("alu_ready_dropped", seen_a_full, 1'b1);
    check("mem_ready_dropped", seen_m_full, 1'b1);

    // ---------------- reset mid-stream ----------------
    do_reset();
    a_next = 1; m_next = 9;
    for (int c = 0; c < 6; c++) begin
      ra.addr = a_next[4:0]; ra.data = 32'hC000_0000 | a_next;
      rm.addr = m_next[4:0]; rm.data = 32'hD000_0000 | m_next;
      run_cycle(1'b1, ra, 1'b1, rm, 5'd1, 5'd2, a_acc, m_acc);
      if (a_acc) a_next++;
      if (m_acc) m_next++;
    end
    check("pre_reset_busy", bus.rf_regWrite, 1'b1);
    reset = 1'b1;
    #1;
    check("midreset_regWrite", bus.rf_regWrite, 1'b0);
    check("midreset_mask", bus.pending_mask, 32'd0);
    check("midreset_hazard", bus.chk_hazard, 1'b0);
    check("midreset_alu_ready", bus.alu_ready, 1'b0);
    check("midreset_mem_ready", bus.mem_ready, 1'b0);
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ra.addr = '0; ra.data = '0; rm = ra;
    for (int c = 0; c < 4; c++)
      run_cycle(1'b0, ra, 1'b0, rm, 5'd1, 5'd9, a_acc, m_acc);

    // ---------------- random traffic vs. model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ra.addr = 5'($urandom_range(0, 31)); ra.data = $urandom;
      rm.addr = 5'($urandom_range(0, 31)); rm.data = $urandom;
      run_cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rm,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), a_acc, m_acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
